hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/sat_counter.sv | 28 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the pipeline control blocks.
//   hz_state_e : hazard-controller FSM state encoding
//   REG_ZERO   : architectural zero register index (never a real dependency)
//   pipe_ctl_t : bundle of pipeline register enables/flushes
//   CTL_*      : the four pipeline-control patterns the controller can drive
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } pipe_ctl_t;

  // Free-running pipeline.
  localparam pipe_ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  // Whole pipe frozen; the access stuck in MEM must not retire, so MEM/WB gets a bubble.
  localparam pipe_ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  // Taken branch: squash the two younger instructions, redirect PC.
  localparam pipe_ctl_t CTL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Load-use: hold PC and IF/ID, inject a bubble into EX.
  localparam pipe_ctl_t CTL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- W-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (clears count)
//   inc    in  count one event this cycle
//   count  out current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
// Resolves memory-wait, taken-branch and load-use hazards (in that priority),
// flags a sticky error when a memory access never completes, and keeps
// saturating stall/flush performance counters.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_id_rs/rt, if_id_uses_rt     source operands of the instruction in ID
//   id_ex_rt, id_ex_mem_read       destination / load flag of the instruction in EX
//   ex_branch_taken                branch/jump resolved taken in EX
//   ex_mem_mem_read/write, mem_ready  MEM-stage access and its completion
//   pc_write .. mem_wb_flush       pipeline register enables / flushes (combinational)
//   mem_err                        sticky memory-timeout flag
//   stall_cnt, flush_cnt           saturating performance counters
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic [4:0]       id_ex_rt,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_mem_read,
  input  logic             ex_mem_mem_write,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

  hz_state_e  r_state;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  logic       w_memh;
  logic       w_luh;
  logic [7:0] w_wait_next;
  pipe_ctl_t  w_ctl;

  assign w_memh = (ex_mem_mem_read | ex_mem_mem_write) & ~mem_ready;

  // Loads into r0 never create a dependency; RT only matters when ID reads it.
  assign w_luh = id_ex_mem_read & (id_ex_rt != REG_ZERO) &
                 ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

  assign w_wait_next = r_wait_cnt + 8'd1;

  // RUN and MEM_WAIT share the same priority resolution; only ERROR overrides it.
  // Reset forces r_state to RUN, so outputs during reset follow the RUN evaluation.
  always_comb begin
    w_ctl = CTL_RUN;
    if (r_state == ERROR) begin
      w_ctl = CTL_FREEZE;
    end else if (w_memh) begin
      w_ctl = CTL_FREEZE;
    end else if (ex_branch_taken) begin
      w_ctl = CTL_BRANCH;
    end else if (w_luh) begin
      w_ctl = CTL_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_memh) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (w_memh) begin
            r_wait_cnt <= w_wait_next;
            // Trip on the edge where the count would reach the limit.
            if (w_wait_next == TIMEOUT_V) begin
              r_state   <= ERROR;
              r_mem_err <= 1'b1;
            end
          end else begin
            r_state <= RUN;
          end
        end
        ERROR: begin
          r_state   <= ERROR;
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign pc_write     = w_ctl.pc_write;
  assign if_id_write  = w_ctl.if_id_write;
  assign if_id_flush  = w_ctl.if_id_flush;
  assign id_ex_write  = w_ctl.id_ex_write;
  assign id_ex_flush  = w_ctl.id_ex_flush;
  assign ex_mem_write = w_ctl.ex_mem_write;
  assign mem_wb_flush = w_ctl.mem_wb_flush;
  assign mem_err      = r_mem_err;

  // A held PC is the definition of a stall, which also covers ERROR cycles.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~w_ctl.pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ctl.if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed scoreboard bench for hazard_ctrl.
// Valid/ready note: the controller has no handshake; every cycle in which the
// driver has pushed an expectation is a "valid" output cycle, and the monitor
// consumes exactly one expectation per such cycle at the falling edge.
// Expected vector layout (14 bits):
//   {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
//    ex_mem_write, mem_wb_flush, mem_err, stall_cnt[2:0], flush_cnt[2:0]}
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 3;
  localparam int VW = 14;

  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
  logic          if_id_uses_rt = 0, id_ex_mem_read = 0, ex_branch_taken = 0;
  logic          ex_mem_mem_read = 0, ex_mem_mem_write = 0, mem_ready = 0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_write, mem_wb_flush, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .if_id_uses_rt    (if_id_uses_rt),
    .id_ex_rt         (id_ex_rt),
    .id_ex_mem_read   (id_ex_mem_read),
    .ex_branch_taken  (ex_branch_taken),
    .ex_mem_mem_read  (ex_mem_mem_read),
    .ex_mem_mem_write (ex_mem_mem_write),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_write      (id_ex_write),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_write     (ex_mem_write),
    .mem_wb_flush     (mem_wb_flush),
    .mem_err          (mem_err),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [VW-1:0] ev(input logic [6:0] ctl, input logic err,
                                       input int st, input int fl);
    return {ctl, err, st[CW-1:0], fl[CW-1:0]};
  endfunction

  logic [VW-1:0] act;
  assign act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, mem_wb_flush, mem_err, stall_cnt, flush_cnt};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [VW-1:0] e;
      string         n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got=%b expected=%b", n, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input string name, input logic [VW-1:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    if_id_rs = 0; if_id_rt = 0; if_id_uses_rt = 0;
    id_ex_rt = 0; id_ex_mem_read = 0; ex_branch_taken = 0;
    ex_mem_mem_read = 0; ex_mem_mem_write = 0; mem_ready = 0;
  endtask

  task automatic set_luh();
    id_ex_mem_read = 1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
  endtask

  task automatic pulse_reset();
    set_idle();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset: RUN evaluation of current inputs, counters held at zero.
    step("reset_idle", ev(C_RUN, 0, 0, 0));
    set_luh();
    step("reset_luh", ev(C_LU, 0, 0, 0));
    set_idle();
    rst_n = 1;
    step("run_idle", ev(C_RUN, 0, 0, 0));

    // Load-use bubble and zero-register / unused-RT exclusions.
    set_luh();
    step("luh", ev(C_LU, 0, 0, 0));
    set_idle();
    step("luh_after", ev(C_RUN, 0, 1, 0));
    id_ex_mem_read = 1;
    step("zero_reg", ev(C_RUN, 0, 1, 0));
    id_ex_rt = 5'd7; if_id_rt = 5'd7; if_id_rs = 5'd3; if_id_uses_rt = 0;
    step("rt_unused", ev(C_RUN, 0, 1, 0));
    if_id_uses_rt = 1;
    step("rt_used", ev(C_LU, 0, 1, 0));
    set_idle();
    step("rt_after", ev(C_RUN, 0, 2, 0));
    ex_branch_taken = 1;
    step("branch", ev(C_BR, 0, 2, 0));
    set_idle();
    step("branch_after", ev(C_RUN, 0, 2, 1));

    // Memory wait: 3 frozen cycles then completion.
    pulse_reset();
    step("post_reset", ev(C_RUN, 0, 0, 0));
    ex_mem_mem_read = 1;
    step("mw1", ev(C_FRZ, 0, 0, 0));
    step("mw2", ev(C_FRZ, 0, 1, 0));
    step("mw3", ev(C_FRZ, 0, 2, 0));
    mem_ready = 1;
    step("mw_ready", ev(C_RUN, 0, 3, 0));
    set_idle();
    step("mw_done", ev(C_RUN, 0, 3, 0));
    ex_mem_mem_write = 1;
    step("store_wait", ev(C_FRZ, 0, 3, 0));
    mem_ready = 1;
    step("store_ready", ev(C_RUN, 0, 4, 0));

    // Simultaneous memh + branch + luh: freeze wins, flush pair on completion.
    pulse_reset();
    ex_mem_mem_read = 1; ex_branch_taken = 1; set_luh();
    step("simul_frz", ev(C_FRZ, 0, 0, 0));
    mem_ready = 1;
    step("simul_ready", ev(C_BR, 0, 1, 0));
    set_idle();
    step("simul_after", ev(C_RUN, 0, 1, 1));
    // Luh alone in the mem_ready cycle out of MEM_WAIT.
    ex_mem_mem_read = 1;
    step("wait_luh_frz", ev(C_FRZ, 0, 1, 1));
    mem_ready = 1; set_luh();
    step("wait_luh_ready", ev(C_LU, 0, 2, 1));

    // Reset mid-wait: no residual stall.
    pulse_reset();
    ex_mem_mem_read = 1;
    step("abort_frz1", ev(C_FRZ, 0, 0, 0));
    step("abort_frz2", ev(C_FRZ, 0, 1, 0));
    pulse_reset();
    step("abort_after", ev(C_RUN, 0, 0, 0));

    // Timeout: 4 MEM_WAIT cycles without completion, then sticky ERROR.
    pulse_reset();
    ex_mem_mem_read = 1;
    step("to_run", ev(C_FRZ, 0, 0, 0));
    for (int i = 1; i <= 4; i++) step("to_wait", ev(C_FRZ, 0, i, 0));
    set_idle(); mem_ready = 1; ex_branch_taken = 1;
    step("err_1", ev(C_FRZ, 1, 5, 0));
    step("err_2", ev(C_FRZ, 1, 6, 0));
    step("err_3", ev(C_FRZ, 1, 7, 0));
    step("err_sat", ev(C_FRZ, 1, 7, 0));
    set_idle();
    rst_n = 0;
    step("err_in_reset", ev(C_RUN, 0, 0, 0));
    rst_n = 1;
    step("err_released", ev(C_RUN, 0, 0, 0));

    // Saturation of both counters.
    set_luh();
    for (int i = 0; i < 10; i++) step("stall_sat", ev(C_LU, 0, (i > 7) ? 7 : i, 0));
    set_idle();
    step("stall_hold", ev(C_RUN, 0, 7, 0));
    ex_branch_taken = 1;
    for (int i = 0; i < 9; i++) step("flush_sat", ev(C_BR, 0, 7, (i > 7) ? 7 : i));
    set_idle();
    step("flush_hold", ev(C_RUN, 0, 7, 7));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
